rf_wb_arbiter: RTL and testbench
================================

RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rstn, input, 1 bit: reset, synchronous, active-low.
REQ-003 SHALL have port sw_i, input, 16 bits: board switches; sw_i[1]=1 freezes writeback.
REQ-004 SHALL have ports a_valid (in, 1), a_addr (in, 5), a_data (in, 32), a_ready (out, 1): ALU writeback requester.
REQ-005 SHALL have ports b_valid (in, 1), b_addr (in, 5), b_data (in, 32), b_ready (out, 1): load writeback requester.
REQ-006 SHALL have ports RFWr (out, 1), A3 (out, 5), WD (out, 32): the single register-file write port, all registered.
REQ-007 SHALL have port wr_cnt, output, 16 bits: count of committed nonzero-address writes.
REQ-008 SHALL have port busy, output, 1 bit: high while either holding slot is full.

Function
REQ-009 SHALL hold one pending entry per requester (slot A, slot B), each storing addr, data and full flag.
REQ-010 SHALL accept on a rising edge when x_valid && x_ready; the entry is captured into slot x.
REQ-011 SHALL drive x_ready = !slot_x_full || grant_x, where grant_x is this cycle's grant; x_ready SHALL NOT depend on x_valid.
REQ-012 SHALL evaluate the grant each cycle among full slots.
REQ-013 SHALL issue no grant while sw_i[1]=1; slots hold their entries; x_ready = !slot_x_full.
REQ-014 SHALL grant the only full slot when exactly one slot is full.
REQ-015 SHALL grant the older slot when both slots are full with equal addr; on same-edge capture, B is older.
REQ-016 SHALL otherwise grant the slot not granted last (round-robin pointer rr; rr=A after reset means A is granted first).
REQ-017 SHALL, on a granted edge, clear the slot (unless refilled the same edge), update rr, and register A3/WD from the entry.
REQ-018 SHALL set RFWr=1 for exactly one cycle per grant when the entry addr != 0, and RFWr=0 otherwise.
REQ-019 SHALL drop addr-0 entries: the slot is consumed, RFWr stays 0, and wr_cnt is unchanged.
REQ-020 SHALL increment wr_cnt by 1 on each edge that sets RFWr=1; wr_cnt wraps 0xFFFF->0x0000.
REQ-021 SHALL give a latency of: accept at edge k, uncontended, gives RFWr high during the cycle after edge k+1.
REQ-022 SHALL give a sustained throughput of one write per cycle; each requester gets at least one grant in every two cycles under contention.
REQ-023 SHALL hold RFWr=0 on cycles without a grant; A3/WD keep their last value.

Reset
REQ-024 SHALL, while rstn=0 at an edge, clear both slots, set RFWr=0, A3=0, WD=0, wr_cnt=0, rr=A and age=B-older.
REQ-025 SHALL discard pending entries on reset mid-operation with no write issued; a_ready=b_ready=1 on the first cycle after release.

Structure
REQ-026 SHALL place ADDR_W=5, DATA_W=32, FREEZE_BIT=1 and the slot-select encoding (SEL_A, SEL_B) in shared package rf_pkg.
REQ-027 SHALL implement each holding slot as sub-module wb_slot, instantiated twice; the arbitration logic stays in rf_wb_arbiter.

Verification
REQ-028 SHALL cover a single write: a_valid, a_addr=5, a_data=0x12345678 for one cycle -> RFWr=1, A3=5, WD=0x12345678 one cycle after the next edge; wr_cnt=1.
REQ-029 SHALL cover contention: both valid every cycle with distinct addrs 1/2 -> grants alternate A,B,A,B; one RFWr per cycle; no stall longer than 1 cycle.
REQ-030 SHALL cover the same-address order: A addr=7 data=0xAAAA and B addr=7 data=0xBBBB accepted on the same edge -> B written first, then A; final write WD=0xAAAA.
REQ-031 SHALL cover freeze: sw_i[1]=1 with both slots full -> RFWr=0, a_ready=b_ready=0, busy=1; release sw_i[1] -> both writes drain over two cycles.
REQ-032 SHALL cover addr 0 and wrap: write to addr 0 -> RFWr stays 0 and wr_cnt unchanged; preset wr_cnt=0xFFFF via 65535 writes, one more write -> wr_cnt=0x0000.
REQ-033 SHALL cover reset mid-flight: both slots full, rstn=0 for one edge -> no RFWr, busy=0, wr_cnt=0, readies high.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared widths, slot-select encoding and the writeback entry type
// used by the register-file writeback arbiter.
package rf_pkg;

    localparam int unsigned ADDR_W     = 5;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned SW_W       = 16;
    localparam int unsigned CNT_W      = 16;
    localparam int unsigned FREEZE_BIT = 1;

    typedef enum logic {
        SEL_A = 1'b0,
        SEL_B = 1'b1
    } sel_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    function automatic sel_e other_sel(input sel_e s);
        return (s == SEL_A) ? SEL_B : SEL_A;
    endfunction

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Writeback requester handshakes plus the register-file write port.
interface rf_wb_arbiter_if;
    import rf_pkg::*;

    logic              a_valid;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_data;
    logic              a_ready;
    logic              b_valid;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_data;
    logic              b_ready;
    logic              RFWr;
    logic [ADDR_W-1:0] A3;
    logic [DATA_W-1:0] WD;
    logic [CNT_W-1:0]  wr_cnt;
    logic              busy;

    modport master (
        output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
        input  a_ready, b_ready, RFWr, A3, WD, wr_cnt, busy
    );

    modport slave (
        input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
        output a_ready, b_ready, RFWr, A3, WD, wr_cnt, busy
    );

endinterface

// File: rtl/wb_slot.sv
// Single-entry holding slot: a load wins over a same-edge clear so a
// granted slot can be refilled without a bubble.
module wb_slot
    import rf_pkg::*;
(
    input  logic      clk,
    input  logic      rstn,
    input  logic      i_load,
    input  logic      i_clear,
    input  wb_entry_t i_entry,
    output logic      o_full,
    output wb_entry_t o_entry
);

    logic      r_full;
    wb_entry_t r_entry;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_full  <= 1'b0;
            r_entry <= '0;
        end else if (i_load) begin
            r_full  <= 1'b1;
            r_entry <= i_entry;
        end else if (i_clear) begin
            r_full  <= 1'b0;
        end
    end

    assign o_full  = r_full;
    assign o_entry = r_entry;

endmodule

// File: rtl/rf_wb_arbiter.sv
// Two-requester register-file writeback arbiter: age order for equal
// addresses, round-robin otherwise, with a board-switch freeze.
module rf_wb_arbiter
    import rf_pkg::*;
(
    input  logic            clk,
    input  logic            rstn,
    input  logic [SW_W-1:0] sw_i,
    rf_wb_arbiter_if.slave  bus
);

    logic      w_freeze;
    logic      w_unused_sw;
    logic      w_a_full, w_b_full;
    logic      w_gnt_vld, w_gnt_a, w_gnt_b;
    logic      w_acc_a, w_acc_b;
    logic      w_a_full_nxt, w_b_full_nxt;
    logic      w_gnt_nz;
    sel_e      w_sel;
    sel_e      r_rr;
    sel_e      r_age;
    wb_entry_t w_a_in, w_b_in, w_a_entry, w_b_entry, w_gnt_entry;

    logic              r_rfwr;
    logic              r_busy;
    logic [ADDR_W-1:0] r_a3;
    logic [DATA_W-1:0] r_wd;
    logic [CNT_W-1:0]  r_cnt;

    assign w_freeze    = sw_i[FREEZE_BIT];
    assign w_unused_sw = ^{sw_i[SW_W-1:FREEZE_BIT+1], sw_i[FREEZE_BIT-1:0]};

    assign w_a_in = '{addr: bus.a_addr, data: bus.a_data};
    assign w_b_in = '{addr: bus.b_addr, data: bus.b_data};

    wb_slot u_slot_a (
        .clk     (clk),
        .rstn    (rstn),
        .i_load  (w_acc_a),
        .i_clear (w_gnt_a),
        .i_entry (w_a_in),
        .o_full  (w_a_full),
        .o_entry (w_a_entry)
    );

    wb_slot u_slot_b (
        .clk     (clk),
        .rstn    (rstn),
        .i_load  (w_acc_b),
        .i_clear (w_gnt_b),
        .i_entry (w_b_in),
        .o_full  (w_b_full),
        .o_entry (w_b_entry)
    );

    // Grant selection: equal addresses must commit in arrival order
    always_comb begin
        w_gnt_vld = 1'b0;
        w_sel     = SEL_A;
        if (!w_freeze) begin
            if (w_a_full && w_b_full) begin
                w_gnt_vld = 1'b1;
                w_sel     = (w_a_entry.addr == w_b_entry.addr) ? r_age : r_rr;
            end else if (w_a_full) begin
                w_gnt_vld = 1'b1;
                w_sel     = SEL_A;
            end else if (w_b_full) begin
                w_gnt_vld = 1'b1;
                w_sel     = SEL_B;
            end
        end
    end

    assign w_gnt_a = w_gnt_vld && (w_sel == SEL_A);
    assign w_gnt_b = w_gnt_vld && (w_sel == SEL_B);

    assign bus.a_ready = !w_a_full || w_gnt_a;
    assign bus.b_ready = !w_b_full || w_gnt_b;

    assign w_acc_a      = bus.a_valid && bus.a_ready;
    assign w_acc_b      = bus.b_valid && bus.b_ready;
    assign w_a_full_nxt = w_acc_a || (w_a_full && !w_gnt_a);
    assign w_b_full_nxt = w_acc_b || (w_b_full && !w_gnt_b);

    assign w_gnt_entry = (w_sel == SEL_A) ? w_a_entry : w_b_entry;
    assign w_gnt_nz    = (w_gnt_entry.addr != '0);

    // Age tracks which slot holds the older entry; same-edge captures make B older
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_rr  <= SEL_A;
            r_age <= SEL_B;
        end else begin
            if (w_gnt_vld) begin
                r_rr <= other_sel(w_sel);
            end
            if (w_acc_a && w_acc_b) begin
                r_age <= SEL_B;
            end else if (w_acc_a && w_b_full && !w_gnt_b) begin
                r_age <= SEL_B;
            end else if (w_acc_b && w_a_full && !w_gnt_a) begin
                r_age <= SEL_A;
            end
        end
    end

    // Register-file write port and commit counter
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_rfwr <= 1'b0;
            r_a3   <= '0;
            r_wd   <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else begin
            r_busy <= w_a_full_nxt || w_b_full_nxt;
            r_rfwr <= 1'b0;
            if (w_gnt_vld) begin
                r_a3   <= w_gnt_entry.addr;
                r_wd   <= w_gnt_entry.data;
                r_rfwr <= w_gnt_nz;
                if (w_gnt_nz) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign bus.RFWr   = r_rfwr;
    assign bus.A3     = r_a3;
    assign bus.WD     = r_wd;
    assign bus.wr_cnt = r_cnt;
    assign bus.busy   = r_busy;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Randomized and directed bench for rf_wb_arbiter against a
// timestamp-based reference model of the two holding slots.
module tb_rf_wb_arbiter;
    import rf_pkg::*;

    logic        clk = 1'b0;
    logic        rstn;
    logic [15:0] sw_i;

    always #5 clk = ~clk;

    rf_wb_arbiter_if bus_if ();

    rf_wb_arbiter u_dut (
        .clk  (clk),
        .rstn (rstn),
        .sw_i (sw_i),
        .bus  (bus_if)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: slot contents with capture timestamps
    logic        m_full  [2];
    logic [4:0]  m_addr  [2];
    logic [31:0] m_data  [2];
    int          m_stamp [2];
    int          m_last;
    int          m_t;
    logic        m_known;
    logic        m_rfwr;
    logic [4:0]  m_a3;
    logic [31:0] m_wd;
    logic [15:0] m_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int model_grant();
        if (sw_i[1]) return -1;
        if (m_full[0] && m_full[1]) begin
            if (m_addr[0] == m_addr[1]) return (m_stamp[0] < m_stamp[1]) ? 0 : 1;
            return 1 - m_last;
        end
        if (m_full[0]) return 0;
        if (m_full[1]) return 1;
        return -1;
    endfunction

    task automatic set_in(input logic va, input logic [4:0] aa, input logic [31:0] ad,
                          input logic vb, input logic [4:0] ba, input logic [31:0] bd);
        bus_if.a_valid = va;
        bus_if.a_addr  = aa;
        bus_if.a_data  = ad;
        bus_if.b_valid = vb;
        bus_if.b_addr  = ba;
        bus_if.b_data  = bd;
    endtask

    task automatic idle();
        set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    // One clock: check readies mid-cycle, advance the model, check registered outputs
    task automatic step();
        int   g;
        logic ra, rb, acc_a, acc_b;
        @(negedge clk);
        g  = model_grant();
        ra = !m_full[0] || (g == 0);
        rb = !m_full[1] || (g == 1);
        if (m_known) begin
            chk("a_ready", 32'(bus_if.a_ready), 32'(ra));
            chk("b_ready", 32'(bus_if.b_ready), 32'(rb));
        end
        acc_a = bus_if.a_valid && ra;
        acc_b = bus_if.b_valid && rb;
        if (!rstn) begin
            m_full[0] = 1'b0;
            m_full[1] = 1'b0;
            m_last    = 1;
            m_rfwr    = 1'b0;
            m_a3      = '0;
            m_wd      = '0;
            m_cnt     = '0;
            m_known   = 1'b1;
        end else begin
            m_rfwr = 1'b0;
            if (g >= 0) begin
                m_a3      = m_addr[g];
                m_wd      = m_data[g];
                m_rfwr    = (m_addr[g] != 5'd0);
                if (m_rfwr) m_cnt = m_cnt + 16'd1;
                m_full[g] = 1'b0;
                m_last    = g;
            end
            if (acc_a) begin
                m_full[0] = 1'b1; m_addr[0] = bus_if.a_addr; m_data[0] = bus_if.a_data; m_stamp[0] = m_t;
            end
            if (acc_b) begin
                m_full[1] = 1'b1; m_addr[1] = bus_if.b_addr; m_data[1] = bus_if.b_data; m_stamp[1] = m_t;
            end
        end
        m_t++;
        @(posedge clk);
        #1;
        if (m_known) begin
            chk("RFWr",   32'(bus_if.RFWr),   32'(m_rfwr));
            chk("A3",     32'(bus_if.A3),     32'(m_a3));
            chk("WD",     bus_if.WD,          m_wd);
            chk("wr_cnt", 32'(bus_if.wr_cnt), 32'(m_cnt));
            chk("busy",   32'(bus_if.busy),   32'(m_full[0] || m_full[1]));
        end
    endtask

    initial begin
        logic [4:0]  prev_a3;
        logic [15:0] exp_cnt;
        m_full[0] = 1'b0; m_full[1] = 1'b0;
        m_addr[0] = '0;   m_addr[1] = '0;
        m_data[0] = '0;   m_data[1] = '0;
        m_stamp[0] = 0;   m_stamp[1] = 0;
        m_last = 1; m_t = 0; m_known = 1'b0;
        m_rfwr = 1'b0; m_a3 = '0; m_wd = '0; m_cnt = '0;

        rstn = 1'b0;
        sw_i = 16'h0000;
        idle();
        step();
        step();
        chk("rst_rfwr",   32'(bus_if.RFWr),   32'd0);
        chk("rst_cnt",    32'(bus_if.wr_cnt), 32'd0);
        chk("rst_busy",   32'(bus_if.busy),   32'd0);
        chk("rst_a_rdy",  32'(bus_if.a_ready), 32'd1);
        chk("rst_b_rdy",  32'(bus_if.b_ready), 32'd1);
        rstn = 1'b1;

        // Single write with fixed latency
        set_in(1'b1, 5'd5, 32'h1234_5678, 1'b0, 5'd0, 32'd0);
        step();
        idle();
        step();
        chk("single_rfwr", 32'(bus_if.RFWr),   32'd1);
        chk("single_a3",   32'(bus_if.A3),     32'd5);
        chk("single_wd",   bus_if.WD,          32'h1234_5678);
        chk("single_cnt",  32'(bus_if.wr_cnt), 32'd1);
        step();
        chk("single_done", 32'(bus_if.RFWr),   32'd0);

        // Contention on distinct addresses alternates every cycle
        prev_a3 = '0;
        for (int i = 0; i < 12; i++) begin
            set_in(1'b1, 5'd1, $urandom, 1'b1, 5'd2, $urandom);
            step();
            if (i >= 2) begin
                chk("contend_wr",  32'(bus_if.RFWr), 32'd1);
                chk("contend_alt", 32'(bus_if.A3 != prev_a3), 32'd1);
            end
            prev_a3 = bus_if.A3;
        end
        idle();
        repeat (3) step();

        // Same address, same edge: B commits first
        set_in(1'b1, 5'd7, 32'h0000_AAAA, 1'b1, 5'd7, 32'h0000_BBBB);
        step();
        idle();
        step();
        chk("same_first_a3", 32'(bus_if.A3), 32'd7);
        chk("same_first_wd", bus_if.WD,      32'h0000_BBBB);
        step();
        chk("same_last_wr",  32'(bus_if.RFWr), 32'd1);
        chk("same_last_wd",  bus_if.WD,        32'h0000_AAAA);
        step();

        // Freeze holds both slots, release drains them over two cycles
        sw_i = 16'h0002;
        set_in(1'b1, 5'd3, 32'h3333_0000, 1'b1, 5'd4, 32'h4444_0000);
        step();
        idle();
        for (int i = 0; i < 3; i++) begin
            step();
            chk("frz_rfwr", 32'(bus_if.RFWr),    32'd0);
            chk("frz_a_rdy", 32'(bus_if.a_ready), 32'd0);
            chk("frz_b_rdy", 32'(bus_if.b_ready), 32'd0);
            chk("frz_busy", 32'(bus_if.busy),    32'd1);
        end
        sw_i = 16'h0000;
        step();
        chk("drain1_wr", 32'(bus_if.RFWr), 32'd1);
        step();
        chk("drain2_wr",   32'(bus_if.RFWr), 32'd1);
        chk("drain2_busy", 32'(bus_if.busy), 32'd0);
        step();
        chk("drain_done", 32'(bus_if.RFWr), 32'd0);

        // Address zero is consumed without a write
        exp_cnt = m_cnt;
        set_in(1'b1, 5'd0, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'd0);
        step();
        idle();
        step();
        chk("a0_rfwr", 32'(bus_if.RFWr),   32'd0);
        chk("a0_cnt",  32'(bus_if.wr_cnt), 32'(exp_cnt));
        chk("a0_busy", 32'(bus_if.busy),   32'd0);

        // Reset with both slots full
        set_in(1'b1, 5'd10, 32'h1010_1010, 1'b1, 5'd11, 32'h1111_1111);
        step();
        rstn = 1'b0;
        idle();
        step();
        chk("mid_rst_rfwr", 32'(bus_if.RFWr),   32'd0);
        chk("mid_rst_busy", 32'(bus_if.busy),   32'd0);
        chk("mid_rst_cnt",  32'(bus_if.wr_cnt), 32'd0);
        rstn = 1'b1;
        chk("mid_rst_a_rdy", 32'(bus_if.a_ready), 32'd1);
        chk("mid_rst_b_rdy", 32'(bus_if.b_ready), 32'd1);
        step();
        chk("mid_rst_nowr", 32'(bus_if.RFWr), 32'd0);

        // Counter wrap after 65535 back-to-back writes
        for (int i = 0; i < 65535; i++) begin
            set_in(1'b1, 5'd9, 32'(i), 1'b0, 5'd0, 32'd0);
            step();
        end
        idle();
        step();
        chk("cnt_full", 32'(bus_if.wr_cnt), 32'h0000_FFFF);
        set_in(1'b1, 5'd9, 32'h5A5A_5A5A, 1'b0, 5'd0, 32'd0);
        step();
        idle();
        step();
        chk("cnt_wrap", 32'(bus_if.wr_cnt), 32'h0000_0000);

        // Random traffic with freezes, small address range and occasional reset
        for (int i = 0; i < 3000; i++) begin
            rstn = ($urandom_range(0, 63) != 0);
            sw_i = 16'($urandom) & 16'hFFFD;
            if ($urandom_range(0, 7) == 0) sw_i[1] = 1'b1;
            set_in(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 3)), $urandom,
                   ($urandom_range(0, 3) != 0), 5'($urandom_range(0, 3)), $urandom);
            step();
        end
        rstn = 1'b1;
        sw_i = 16'h0000;
        idle();
        repeat (4) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
